jtframe_sdram_rqcheck: RTL and testbench
========================================

# jtframe_sdram_rqcheck

Parametrised, synthesisable protocol checker for the per-bank SDRAM request/acknowledge/ready handshake. It sits beside the SDRAM controller, passively watching each bank's read/write request, ack and rdy strobes. It flags protocol violations and ack/rdy timeouts as sticky error bits, so errors are visible in simulation, on hardware debug buses and in signal taps. It never drives the SDRAM path.

## Interface
Parameters:
- BANKS, 4, number of monitored bank channels (1–8).
- ACK_TO, 64, maximum cycles allowed from request edge to ack (≥2).
- RDY_TO, 64, maximum cycles allowed from ack to rdy (≥2).
- CW, 8, width of the internal cycle counters and of max_lat; must hold max(ACK_TO,RDY_TO).

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- ba_rd  in  BANKS  per-bank read request level.
- ba_wr  in  BANKS  per-bank write request level.
- ba_ack  in  BANKS  per-bank single-cycle acknowledge.
- ba_rdy  in  BANKS  per-bank single-cycle data-ready strobe.
- clr  in  1  clears all sticky errors, err_cnt and max_lat.
- err_noreq  out  BANKS  ack seen with no pending request.
- err_noack  out  BANKS  rdy seen without a preceding ack.
- err_ackto  out  BANKS  ack timeout.
- err_rdyto  out  BANKS  rdy timeout.
- err_any  out  1  OR of all error bits, registered.
- err_cnt  out  16  saturating count of cycles in which at least one new error fired.
- max_lat  out  CW  worst-case request-edge-to-rdy latency; only active when the configuration macro is defined.

## Operation
- rq[i] = ba_rd[i] | ba_wr[i].
- Request edge: rq_edge[i] = rq[i] & ~last_rq[i]. last_rq resets to 0.
- Each bank has an independent FSM with states IDLE, WAIT_ACK and WAIT_RDY, plus a CW-bit counter.
- IDLE:
  - rq_edge → WAIT_ACK; counter cleared.
  - ack → err_noreq.
  - rdy → err_noack.
- WAIT_ACK:
  - ack → WAIT_RDY; counter cleared.
  - rdy, including rdy in the same cycle as ack → err_noack. rdy must follow ack by at least 1 cycle.
  - Further rq edges are ignored.
  - Counter reaches ACK_TO−1 with no ack → err_ackto, and the FSM goes to IDLE.
- WAIT_RDY:
  - rdy with no rq_edge → IDLE.
  - rdy together with rq_edge → WAIT_ACK (back-to-back request); counter cleared.
  - ack → err_noreq; the state is unchanged.
  - Counter reaches RDY_TO−1 with no rdy → err_rdyto, and the FSM goes to IDLE.
- Counters saturate and never wrap.
- Error bits:
  - Sticky: set on the violation and held until clr or rst.
  - clr in the same cycle as a new violation: the new violation wins, so the bit stays set.
- err_cnt:
  - +1 per cycle in which any error bit transitions 0→1 across all banks, or a violation re-fires on an already-set bit.
  - Saturates at 16'hFFFF.
- rst mid-transaction: all FSMs go to IDLE and all outputs clear. A pending ack or rdy arriving after reset is reported as err_noreq or err_noack.

## Timing
- Reset values: every output is 0; all FSMs are in IDLE.
- All outputs are registered. Every error appears exactly 1 cycle after the offending input is sampled.
- Request edge sampled at cycle t:
  - ack is accepted in cycles t+1 … t+ACK_TO.
  - If no ack arrives, err_ackto is high at t+ACK_TO+1.
- Ack at cycle a:
  - rdy is accepted in cycles a+1 … a+RDY_TO.
  - If no rdy arrives, err_rdyto is high at a+RDY_TO+1.
- err_any lags the individual error bits by 0 cycles; it is the OR of their next-state values, registered.
- Banks are fully independent. Simultaneous events on different banks are each handled in the same cycle.

## Configuration
- JTFRAME_RQCHK_LAT_EN defined:
  - A per-bank latency counter runs from rq_edge to rdy.
  - On each accepted rdy, max_lat is updated to max(max_lat, latency), where latency is the number of cycles from the edge cycle to the rdy cycle.
  - max_lat saturates at 2^CW−1 and is cleared by rst or clr.
- JTFRAME_RQCHK_LAT_EN undefined: max_lat is tied to 0 and the latency logic is removed.

## Test plan
- Nominal handshake, bank 0: rd rises at cycle 10, ack at cycle 13, rdy at cycle 17 → no error bits set, err_cnt=0. With the latency macro defined, max_lat=7.
- Spurious strobes: ack on bank 2 with no request → err_noreq=4'b0100 one cycle later and err_cnt=1. rdy on bank 1 while in WAIT_ACK → err_noack=4'b0010.
- Timeouts, ACK_TO=RDY_TO=8:
  - Bank 3 request with no ack → err_ackto[3]=1 exactly 9 cycles after the edge.
  - Bank 0 ack with no rdy → err_rdyto[0]=1 exactly 9 cycles after the ack.
- Back-to-back request: rdy on bank 1 and a new wr edge in the same cycle, then ack 2 cycles later and rdy 3 cycles after that → no errors.
- Clear and reset:
  - All banks erroring, then clr pulsed → all outputs 0 on the next cycle.
  - clr coincident with a new err_noreq → that bit stays set.
  - rst asserted in WAIT_RDY, then a late rdy → err_noack set.
- Saturation: force more than 65535 error cycles → err_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/jtframe_sdram_rqcheck.sv
// Passive per-bank SDRAM request/ack/rdy protocol checker with sticky error flags.
// Optional worst-case latency tracking is enabled by defining JTFRAME_RQCHK_LAT_EN.
module jtframe_sdram_rqcheck #(
    parameter int BANKS  = 4,
    parameter int ACK_TO = 64,
    parameter int RDY_TO = 64,
    parameter int CW     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BANKS-1:0] ba_rd,
    input  logic [BANKS-1:0] ba_wr,
    input  logic [BANKS-1:0] ba_ack,
    input  logic [BANKS-1:0] ba_rdy,
    input  logic             clr,
    output logic [BANKS-1:0] err_noreq,
    output logic [BANKS-1:0] err_noack,
    output logic [BANKS-1:0] err_ackto,
    output logic [BANKS-1:0] err_rdyto,
    output logic             err_any,
    output logic [15:0]      err_cnt,
    output logic [CW-1:0]    max_lat
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_ACK = 2'd1,
        S_WAIT_RDY = 2'd2
    } state_t;

    localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TO - 1);
    localparam logic [CW-1:0] RDY_LAST = CW'(RDY_TO - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    state_t          state_q [BANKS];
    state_t          state_d [BANKS];
    logic [CW-1:0]   cnt_q   [BANKS];
    logic [CW-1:0]   cnt_d   [BANKS];

    logic [BANKS-1:0] last_rq_q, last_rq_d;
    logic [BANKS-1:0] rq_s, rq_edge_s;
    logic [BANKS-1:0] new_noreq_s, new_noack_s, new_ackto_s, new_rdyto_s;
    logic [BANKS-1:0] err_noreq_q, err_noreq_d;
    logic [BANKS-1:0] err_noack_q, err_noack_d;
    logic [BANKS-1:0] err_ackto_q, err_ackto_d;
    logic [BANKS-1:0] err_rdyto_q, err_rdyto_d;
    logic             err_any_q, err_any_d;
    logic [15:0]      err_cnt_q, err_cnt_d;
    logic             fire_s;

    assign rq_s      = ba_rd | ba_wr;
    assign rq_edge_s = rq_s & ~last_rq_q;

    // Per-bank handshake FSM next state, counters and violation detection
    always_comb begin
        last_rq_d   = rq_s;
        new_noreq_s = {BANKS{1'b0}};
        new_noack_s = {BANKS{1'b0}};
        new_ackto_s = {BANKS{1'b0}};
        new_rdyto_s = {BANKS{1'b0}};
        for (int b = 0; b < BANKS; b++) begin
            state_d[b] = state_q[b];
            cnt_d[b]   = (cnt_q[b] == CNT_MAX) ? cnt_q[b] : cnt_q[b] + CW'(1);
            case (state_q[b])
                S_IDLE: begin
                    new_noreq_s[b] = ba_ack[b];
                    new_noack_s[b] = ba_rdy[b];
                    if (rq_edge_s[b]) begin
                        state_d[b] = S_WAIT_ACK;
                        cnt_d[b]   = {CW{1'b0}};
                    end else begin
                        cnt_d[b]   = {CW{1'b0}};
                    end
                end
                S_WAIT_ACK: begin
                    // rdy in the same cycle as ack is still premature
                    new_noack_s[b] = ba_rdy[b];
                    if (ba_ack[b]) begin
                        state_d[b] = S_WAIT_RDY;
                        cnt_d[b]   = {CW{1'b0}};
                    end else if (cnt_q[b] == ACK_LAST) begin
                        new_ackto_s[b] = 1'b1;
                        state_d[b]     = S_IDLE;
                    end else begin
                        state_d[b] = S_WAIT_ACK;
                    end
                end
                S_WAIT_RDY: begin
                    new_noreq_s[b] = ba_ack[b];
                    if (ba_rdy[b]) begin
                        if (rq_edge_s[b]) begin
                            state_d[b] = S_WAIT_ACK;
                            cnt_d[b]   = {CW{1'b0}};
                        end else begin
                            state_d[b] = S_IDLE;
                        end
                    end else if (cnt_q[b] == RDY_LAST) begin
                        new_rdyto_s[b] = 1'b1;
                        state_d[b]     = S_IDLE;
                    end else begin
                        state_d[b] = S_WAIT_RDY;
                    end
                end
                default: begin
                    state_d[b] = S_IDLE;
                    cnt_d[b]   = {CW{1'b0}};
                end
            endcase
        end
    end

    // Sticky error bits and saturating error-cycle counter; a new violation beats clr
    always_comb begin
        fire_s      = |{new_noreq_s, new_noack_s, new_ackto_s, new_rdyto_s};
        err_noreq_d = (clr ? {BANKS{1'b0}} : err_noreq_q) | new_noreq_s;
        err_noack_d = (clr ? {BANKS{1'b0}} : err_noack_q) | new_noack_s;
        err_ackto_d = (clr ? {BANKS{1'b0}} : err_ackto_q) | new_ackto_s;
        err_rdyto_d = (clr ? {BANKS{1'b0}} : err_rdyto_q) | new_rdyto_s;
        err_any_d   = |{err_noreq_d, err_noack_d, err_ackto_d, err_rdyto_d};
        if (clr) begin
            err_cnt_d = {15'd0, fire_s};
        end else if (fire_s && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // State, counter and error registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < BANKS; b++) begin
                state_q[b] <= S_IDLE;
                cnt_q[b]   <= {CW{1'b0}};
            end
            last_rq_q   <= {BANKS{1'b0}};
            err_noreq_q <= {BANKS{1'b0}};
            err_noack_q <= {BANKS{1'b0}};
            err_ackto_q <= {BANKS{1'b0}};
            err_rdyto_q <= {BANKS{1'b0}};
            err_any_q   <= 1'b0;
            err_cnt_q   <= 16'd0;
        end else begin
            for (int b = 0; b < BANKS; b++) begin
                state_q[b] <= state_d[b];
                cnt_q[b]   <= cnt_d[b];
            end
            last_rq_q   <= last_rq_d;
            err_noreq_q <= err_noreq_d;
            err_noack_q <= err_noack_d;
            err_ackto_q <= err_ackto_d;
            err_rdyto_q <= err_rdyto_d;
            err_any_q   <= err_any_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign err_noreq = err_noreq_q;
    assign err_noack = err_noack_q;
    assign err_ackto = err_ackto_q;
    assign err_rdyto = err_rdyto_q;
    assign err_any   = err_any_q;
    assign err_cnt   = err_cnt_q;

`ifdef JTFRAME_RQCHK_LAT_EN
    logic [CW-1:0] lat_q [BANKS];
    logic [CW-1:0] lat_d [BANKS];
    logic [CW-1:0] max_lat_q, max_lat_d;

    // Latency counters restart at 1 on an accepted edge so they read rdy-minus-edge at rdy
    always_comb begin
        max_lat_d = clr ? {CW{1'b0}} : max_lat_q;
        for (int b = 0; b < BANKS; b++) begin
            if (rq_edge_s[b] && ((state_q[b] == S_IDLE) ||
                                 ((state_q[b] == S_WAIT_RDY) && ba_rdy[b]))) begin
                lat_d[b] = CW'(1);
            end else if (lat_q[b] != CNT_MAX) begin
                lat_d[b] = lat_q[b] + CW'(1);
            end else begin
                lat_d[b] = lat_q[b];
            end
            if ((state_q[b] == S_WAIT_RDY) && ba_rdy[b] && (lat_q[b] > max_lat_d)) begin
                max_lat_d = lat_q[b];
            end else begin
                max_lat_d = max_lat_d;
            end
        end
    end

    // Latency registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < BANKS; b++) begin
                lat_q[b] <= {CW{1'b0}};
            end
            max_lat_q <= {CW{1'b0}};
        end else begin
            for (int b = 0; b < BANKS; b++) begin
                lat_q[b] <= lat_d[b];
            end
            max_lat_q <= max_lat_d;
        end
    end

    assign max_lat = max_lat_q;
`else
    assign max_lat = {CW{1'b0}};
`endif

endmodule

// File: tb/tb_jtframe_sdram_rqcheck.sv
// Randomised and directed bench for jtframe_sdram_rqcheck against a timestamp-based model.
module tb_jtframe_sdram_rqcheck;

    localparam int BANKS  = 4;
    localparam int ACK_TO = 8;
    localparam int RDY_TO = 8;
    localparam int CW     = 8;

    logic             clk = 1'b0;
    logic             rst, clr;
    logic [BANKS-1:0] ba_rd, ba_wr, ba_ack, ba_rdy;
    logic [BANKS-1:0] err_noreq, err_noack, err_ackto, err_rdyto;
    logic             err_any;
    logic [15:0]      err_cnt;
    logic [CW-1:0]    max_lat;

    always #5 clk = ~clk;

    jtframe_sdram_rqcheck #(.BANKS(BANKS), .ACK_TO(ACK_TO), .RDY_TO(RDY_TO), .CW(CW)) dut (
        .clk(clk), .rst(rst), .ba_rd(ba_rd), .ba_wr(ba_wr), .ba_ack(ba_ack), .ba_rdy(ba_rdy),
        .clr(clr), .err_noreq(err_noreq), .err_noack(err_noack), .err_ackto(err_ackto),
        .err_rdyto(err_rdyto), .err_any(err_any), .err_cnt(err_cnt), .max_lat(max_lat)
    );

    // Model: each bank is idle(0), waiting for ack(1) or waiting for rdy(2),
    // with absolute cycle stamps of the request edge and of the ack.
    int               stage [BANKS];
    longint           t_req [BANKS];
    longint           t_ack [BANKS];
    longint           cyc;
    logic [BANKS-1:0] m_last, m_noreq, m_noack, m_ackto, m_rdyto;
    int               m_cnt, m_max;
    int               n_tests, n_fail;
    logic [BANKS-1:0] rd_l, wr_l;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step(input logic [BANKS-1:0] rd, wr, ack, rdy, input logic c, r);
        logic [BANKS-1:0] nq, na, nat, nrt;
        logic             rq, edg;
        int               lat, base;
        if (r) begin
            for (int b = 0; b < BANKS; b++) stage[b] = 0;
            m_last = '0; m_noreq = '0; m_noack = '0; m_ackto = '0; m_rdyto = '0;
            m_cnt = 0; m_max = 0;
            cyc++;
            return;
        end
        nq = '0; na = '0; nat = '0; nrt = '0;
        base = c ? 0 : m_max;
        for (int b = 0; b < BANKS; b++) begin
            rq  = rd[b] | wr[b];
            edg = rq & ~m_last[b];
            if (stage[b] == 0) begin
                nq[b] = ack[b];
                na[b] = rdy[b];
                if (edg) begin stage[b] = 1; t_req[b] = cyc; end
            end else if (stage[b] == 1) begin
                na[b] = rdy[b];
                if (ack[b]) begin
                    stage[b] = 2; t_ack[b] = cyc;
                end else if (cyc - t_req[b] == ACK_TO) begin
                    nat[b] = 1'b1; stage[b] = 0;
                end
            end else begin
                nq[b] = ack[b];
                if (rdy[b]) begin
                    lat = int'(cyc - t_req[b]);
                    if (lat > 255) lat = 255;
                    if (lat > base) base = lat;
                    if (edg) begin stage[b] = 1; t_req[b] = cyc; end
                    else stage[b] = 0;
                end else if (cyc - t_ack[b] == RDY_TO) begin
                    nrt[b] = 1'b1; stage[b] = 0;
                end
            end
            m_last[b] = rq;
        end
        m_max   = base;
        m_noreq = (c ? '0 : m_noreq) | nq;
        m_noack = (c ? '0 : m_noack) | na;
        m_ackto = (c ? '0 : m_ackto) | nat;
        m_rdyto = (c ? '0 : m_rdyto) | nrt;
        if (c) m_cnt = (|{nq, na, nat, nrt}) ? 1 : 0;
        else if ((|{nq, na, nat, nrt}) && m_cnt < 65535) m_cnt++;
        cyc++;
    endtask

    task automatic compare_all();
        chk("err_noreq", 32'(err_noreq), 32'(m_noreq));
        chk("err_noack", 32'(err_noack), 32'(m_noack));
        chk("err_ackto", 32'(err_ackto), 32'(m_ackto));
        chk("err_rdyto", 32'(err_rdyto), 32'(m_rdyto));
        chk("err_any", 32'(err_any), 32'(|{m_noreq, m_noack, m_ackto, m_rdyto}));
        chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
`ifdef JTFRAME_RQCHK_LAT_EN
        chk("max_lat", 32'(max_lat), 32'(m_max));
`else
        chk("max_lat", 32'(max_lat), 32'd0);
`endif
    endtask

    task automatic tick(input logic [BANKS-1:0] ack, rdy, input logic c, r);
        ba_rd = rd_l; ba_wr = wr_l; ba_ack = ack; ba_rdy = rdy; clr = c; rst = r;
        model_step(rd_l, wr_l, ack, rdy, c, r);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        repeat (n) tick(4'b0000, 4'b0000, 1'b0, 1'b0);
    endtask

    initial begin
        logic [BANKS-1:0] a, y;
        n_tests = 0; n_fail = 0; cyc = 0;
        rd_l = '0; wr_l = '0;
        ba_rd = '0; ba_wr = '0; ba_ack = '0; ba_rdy = '0; clr = 1'b0; rst = 1'b1;
        for (int b = 0; b < BANKS; b++) begin stage[b] = 0; t_req[b] = 0; t_ack[b] = 0; end
        m_last = '0; m_noreq = '0; m_noack = '0; m_ackto = '0; m_rdyto = '0;
        m_cnt = 0; m_max = 0;
        @(negedge clk);
        tick(4'b0000, 4'b0000, 1'b0, 1'b1);
        tick(4'b0000, 4'b0000, 1'b0, 1'b1);
        chk("reset_outputs", {err_noreq, err_noack, err_ackto, err_rdyto, err_any, err_cnt}, 32'd0);
        chk("reset_max_lat", 32'(max_lat), 32'd0);

        // nominal: edge at t, ack at t+3, rdy at t+7
        idle(2);
        rd_l = 4'b0001; tick(4'b0000, 4'b0000, 1'b0, 1'b0);
        idle(2);
        tick(4'b0001, 4'b0000, 1'b0, 1'b0);
        idle(3);
        rd_l = 4'b0000; tick(4'b0000, 4'b0001, 1'b0, 1'b0);
        chk("nominal_err_any", 32'(err_any), 32'd0);
        chk("nominal_err_cnt", 32'(err_cnt), 32'd0);
`ifdef JTFRAME_RQCHK_LAT_EN
        chk("nominal_max_lat", 32'(max_lat), 32'd7);
`endif

        // spurious ack on bank 2, then premature rdy on bank 1
        tick(4'b0100, 4'b0000, 1'b0, 1'b0);
        chk("spur_noreq", 32'(err_noreq), 32'h4);
        chk("spur_cnt", 32'(err_cnt), 32'd1);
        rd_l = 4'b0010; tick(4'b0000, 4'b0000, 1'b0, 1'b0);
        tick(4'b0000, 4'b0010, 1'b0, 1'b0);
        chk("spur_noack", 32'(err_noack), 32'h2);
        tick(4'b0010, 4'b0000, 1'b0, 1'b0);
        rd_l = 4'b0000; tick(4'b0000, 4'b0010, 1'b0, 1'b0);

        // every bank erroring, then clr
        tick(4'b1111, 4'b1111, 1'b0, 1'b0);
        chk("all_noreq", 32'(err_noreq), 32'hF);
        tick(4'b0000, 4'b0000, 1'b1, 1'b0);
        chk("clr_outputs", {err_noreq, err_noack, err_ackto, err_rdyto, err_any, err_cnt}, 32'd0);
        chk("clr_max_lat", 32'(max_lat), 32'd0);

        // ack timeout on bank 3: visible exactly 9 cycles after the edge
        rd_l = 4'b1000; tick(4'b0000, 4'b0000, 1'b0, 1'b0);
        idle(7);
        chk("ackto_early", 32'(err_ackto), 32'h0);
        idle(1);
        chk("ackto_exact", 32'(err_ackto), 32'h8);
        rd_l = 4'b0000;

        // rdy timeout on bank 0: visible exactly 9 cycles after the ack
        rd_l = 4'b0001; tick(4'b0000, 4'b0000, 1'b0, 1'b0);
        tick(4'b0001, 4'b0000, 1'b0, 1'b0);
        idle(7);
        chk("rdyto_early", 32'(err_rdyto), 32'h0);
        idle(1);
        chk("rdyto_exact", 32'(err_rdyto), 32'h1);
        rd_l = 4'b0000;
        tick(4'b0000, 4'b0000, 1'b1, 1'b0);

        // back-to-back on bank 1: rdy with a new wr edge, ack +2, rdy +3
        rd_l = 4'b0010; tick(4'b0000, 4'b0000, 1'b0, 1'b0);
        tick(4'b0010, 4'b0000, 1'b0, 1'b0);
        rd_l = 4'b0000; idle(1);
        wr_l = 4'b0010; tick(4'b0000, 4'b0010, 1'b0, 1'b0);
        idle(1);
        tick(4'b0010, 4'b0000, 1'b0, 1'b0);
        idle(2);
        wr_l = 4'b0000; tick(4'b0000, 4'b0010, 1'b0, 1'b0);
        chk("b2b_err_any", 32'(err_any), 32'd0);
        chk("b2b_err_cnt", 32'(err_cnt), 32'd0);

        // clr coincident with a new noreq
        tick(4'b0001, 4'b0000, 1'b0, 1'b0);
        tick(4'b0100, 4'b0000, 1'b1, 1'b0);
        chk("clr_vs_new", 32'(err_noreq), 32'h4);

        // rst while waiting for rdy, then the late rdy
        rd_l = 4'b0001; tick(4'b0000, 4'b0000, 1'b0, 1'b0);
        tick(4'b0001, 4'b0000, 1'b0, 1'b0);
        rd_l = 4'b0000; tick(4'b0000, 4'b0000, 1'b0, 1'b1);
        tick(4'b0000, 4'b0001, 1'b0, 1'b0);
        chk("rst_late_rdy", 32'(err_noack), 32'h1);

        // randomised traffic, biased towards legal responses
        tick(4'b0000, 4'b0000, 1'b1, 1'b0);
        repeat (4000) begin
            for (int b = 0; b < BANKS; b++) begin
                if ($urandom_range(0, 7) == 0) rd_l[b] = ~rd_l[b];
                if ($urandom_range(0, 9) == 0) wr_l[b] = ~wr_l[b];
                a[b] = (stage[b] == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 11) == 0);
                y[b] = (stage[b] == 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 11) == 0);
            end
            tick(a, y, $urandom_range(0, 199) == 0, $urandom_range(0, 499) == 0);
        end

        // error counter saturation
        rd_l = '0; wr_l = '0;
        tick(4'b0000, 4'b0000, 1'b1, 1'b0);
        repeat (66000) tick(4'b0001, 4'b0000, 1'b0, 1'b0);
        chk("cnt_saturated", 32'(err_cnt), 32'h0000FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
